// File: rtl/mm_cdr_pkg.sv
// Shared types and helpers for the MM clock-and-data-recovery loop filter.
package mm_cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_OVRD   = 2'd3
  } lf_state_t;

  function automatic int nsum_w(input int nadc, input int ndec);
    return nadc + $clog2(ndec);
  endfunction

  function automatic int nph_w(input int nout, input int nfrac);
    return nout + nfrac;
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end else begin
      return s[31:0];
    end
  endfunction

endpackage

// File: rtl/mm_lock_det.sv
// Lock detector: counts consecutive quiet windows and applies a 2x exit hysteresis.
module mm_lock_det
  import mm_cdr_pkg::*;
#(
  parameter int Nsum    = 10,
  parameter int Nthr    = 8,
  parameter int LockCnt = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   win_close,
  input  logic signed [Nsum-1:0] sum,
  input  logic [Nthr-1:0]        lock_thr,
  output logic                   lock_nxt,
  output logic                   lock
);

  localparam int Ncw = $clog2(LockCnt + 1);
  localparam logic [Ncw-1:0] CntMax = Ncw'(LockCnt);

  logic [Ncw-1:0]  cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic [Nsum-1:0] abs_sum;
  logic            in_thr;
  logic            above_2thr;

  always_comb begin
    abs_sum    = sum[Nsum-1] ? Nsum'(-sum) : Nsum'(sum);
    in_thr     = 32'(abs_sum) <= 32'(lock_thr);
    above_2thr = 32'(abs_sum) > (32'(lock_thr) << 1);
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    if (clr) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (win_close) begin
      if (!in_thr) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + Ncw'(1);
      end
      if (!lock_q && (cnt_d == CntMax)) begin
        lock_d = 1'b1;
      end else if (lock_q && above_2thr) begin
        lock_d = 1'b0;
      end else begin
        lock_d = lock_q;
      end
    end else begin
      cnt_d  = cnt_q;
      lock_d = lock_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock_nxt = lock_d;
  assign lock     = lock_q;

endmodule

// File: rtl/mm_loop_filter.sv
// Proportional + integral CDR loop filter: decimates phase error, drives the PI code.
module mm_loop_filter
  import mm_cdr_pkg::*;
#(
  parameter int Nadc    = 8,
  parameter int Ndec    = 4,
  parameter int Nacc    = 12,
  parameter int Nout    = 8,
  parameter int Nfrac   = 8,
  parameter int LockCnt = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [Nadc-1:0] pd_in,
  input  logic [3:0]             kp,
  input  logic [3:0]             ki,
  input  logic [Nadc-1:0]        lock_thr,
  input  logic                   ext_ovrd,
  input  logic [Nout-1:0]        ext_code,
  output logic [Nout-1:0]        code_out,
  output logic                   code_vld,
  output logic                   lock
);

  localparam int Nsum = nsum_w(Nadc, Ndec);
  localparam int Nph  = nph_w(Nout, Nfrac);
  localparam int Ndw  = (Ndec > 1) ? $clog2(Ndec) : 1;
  localparam logic [Ndw-1:0] DecLast = Ndw'(Ndec - 1);

  lf_state_t              state_q, state_d;
  logic signed [Nsum-1:0] sum_q, sum_d;
  logic [Ndw-1:0]         dec_cnt_q, dec_cnt_d;
  logic signed [Nacc-1:0] int_acc_q, int_acc_d;
  logic [Nph-1:0]         phase_acc_q, phase_acc_d;
  logic [Nout-1:0]        code_q, code_d;
  logic                   code_vld_q, code_vld_d;

  logic                   go_active;
  logic                   sample;
  logic                   win_close;
  logic                   lock_nxt;
  logic signed [Nsum-1:0] full_sum;
  logic signed [31:0]     sum_ext;
  logic signed [31:0]     int_new;
  logic signed [31:0]     step;
  logic [Nph-1:0]         phase_new;

  // Override wins over enable; within the running states the lock detector picks ACQ/LOCKED.
  always_comb begin
    state_d = state_q;
    if (ext_ovrd) begin
      state_d = ST_OVRD;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else if (lock_nxt) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_ACQ;
    end
  end

  always_comb begin
    go_active = en && !ext_ovrd;
    sample    = go_active && ((state_q == ST_ACQ) || (state_q == ST_LOCKED));
    full_sum  = sum_q + Nsum'(pd_in);
    win_close = sample && (dec_cnt_q == DecLast);
    sum_ext   = 32'(full_sum);
    int_new   = sat_add(32'(int_acc_q), sum_ext >>> ki, Nacc);
    step      = (sum_ext >>> kp) + int_new;
    phase_new = phase_acc_q + step[Nph-1:0];

    sum_d       = sum_q;
    dec_cnt_d   = dec_cnt_q;
    int_acc_d   = int_acc_q;
    phase_acc_d = phase_acc_q;
    code_d      = code_q;
    code_vld_d  = 1'b0;
    if (ext_ovrd) begin
      sum_d       = '0;
      dec_cnt_d   = '0;
      phase_acc_d = {ext_code, {Nfrac{1'b0}}};
      code_d      = ext_code;
      code_vld_d  = (ext_code != code_q);
    end else if (!sample) begin
      // Idle, or the first cycle after entering ACQ: no sample taken, window restarts clean.
      sum_d     = '0;
      dec_cnt_d = '0;
    end else if (win_close) begin
      sum_d       = '0;
      dec_cnt_d   = '0;
      int_acc_d   = int_new[Nacc-1:0];
      phase_acc_d = phase_new;
      code_d      = phase_new[Nph-1:Nfrac];
      code_vld_d  = 1'b1;
    end else begin
      sum_d     = full_sum;
      dec_cnt_d = dec_cnt_q + Ndw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      dec_cnt_q   <= '0;
      int_acc_q   <= '0;
      phase_acc_q <= '0;
      code_q      <= '0;
      code_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      dec_cnt_q   <= dec_cnt_d;
      int_acc_q   <= int_acc_d;
      phase_acc_q <= phase_acc_d;
      code_q      <= code_d;
      code_vld_q  <= code_vld_d;
    end
  end

  mm_lock_det #(
    .Nsum    (Nsum),
    .Nthr    (Nadc),
    .LockCnt (LockCnt)
  ) u_lock_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (!go_active),
    .win_close (win_close),
    .sum       (full_sum),
    .lock_thr  (lock_thr),
    .lock_nxt  (lock_nxt),
    .lock      (lock)
  );

  assign code_out = code_q;
  assign code_vld = code_vld_q;

endmodule

// File: tb/tb_mm_loop_filter.sv
// Directed plus randomized bench for mm_loop_filter against a window-level reference model.
module tb_mm_loop_filter;

  localparam int NDEC = 4;
  localparam int LOCK_N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic signed [7:0] pd_in;
  logic [3:0]        kp;
  logic [3:0]        ki;
  logic [7:0]        lock_thr;
  logic              ext_ovrd;
  logic [7:0]        ext_code;
  logic [7:0]        code_out;
  logic              code_vld;
  logic              lock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 running, 2 override; samples collected per window.
  int m_mode;
  int m_win[$];
  int m_int;
  int m_phase;
  int m_code;
  int m_lockc;
  bit m_vld;
  bit m_lock;

  always #5 clk = ~clk;

  mm_loop_filter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pd_in    (pd_in),
    .kp       (kp),
    .ki       (ki),
    .lock_thr (lock_thr),
    .ext_ovrd (ext_ovrd),
    .ext_code (ext_code),
    .code_out (code_out),
    .code_vld (code_vld),
    .lock     (lock)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic close_window();
    int s;
    int a;
    s = 0;
    foreach (m_win[i]) s += m_win[i];
    m_win.delete();
    m_int = m_int + (s >>> ki);
    if (m_int > 2047) m_int = 2047;
    if (m_int < -2048) m_int = -2048;
    m_phase = (m_phase + (s >>> kp) + m_int) & 32'h0000FFFF;
    m_code  = m_phase / 256;
    m_vld   = 1'b1;
    a = (s < 0) ? -s : s;
    if (a <= int'(lock_thr)) m_lockc = (m_lockc < LOCK_N) ? m_lockc + 1 : LOCK_N;
    else m_lockc = 0;
    if (!m_lock && m_lockc == LOCK_N) m_lock = 1'b1;
    else if (m_lock && a > 2 * int'(lock_thr)) m_lock = 1'b0;
  endtask

  task automatic model_edge();
    m_vld = 1'b0;
    if (rst) begin
      m_mode = 0; m_win.delete(); m_int = 0; m_phase = 0; m_code = 0; m_lockc = 0; m_lock = 1'b0;
    end else if (ext_ovrd) begin
      m_win.delete(); m_lockc = 0; m_lock = 1'b0;
      m_vld   = (int'(ext_code) != m_code);
      m_code  = int'(ext_code);
      m_phase = int'(ext_code) * 256;
      m_mode  = 2;
    end else if (!en) begin
      m_win.delete(); m_lockc = 0; m_lock = 1'b0; m_mode = 0;
    end else begin
      if (m_mode == 1) begin
        m_win.push_back(int'(pd_in));
        if (m_win.size() == NDEC) close_window();
      end
      m_mode = 1;
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("code_out", code_out, m_code);
      check("code_vld", code_vld, m_vld);
      check("lock", lock, m_lock);
      check("int_acc", dut.int_acc_q, m_int);
      check("phase_acc", dut.phase_acc_q, m_phase);
    end
  endtask

  initial begin
    int r;
    int tmp;
    m_mode = 0; m_int = 0; m_phase = 0; m_code = 0; m_lockc = 0; m_vld = 1'b0; m_lock = 1'b0;

    // Reset held with active-looking inputs
    rst = 1'b1; en = 1'b1; pd_in = 8'sd50; kp = 4'd0; ki = 4'd0;
    lock_thr = 8'd0; ext_ovrd = 1'b0; ext_code = 8'h00;
    tick(2);
    check("rst_code", code_out, 0);
    check("rst_vld", code_vld, 0);

    // Tracking with constant +4
    rst = 1'b0; pd_in = 8'sd4;
    tick(5);
    check("trk_w1_phase", dut.phase_acc_q, 32);
    check("trk_w1_vld", code_vld, 1);
    tick(8);
    check("trk_w3_phase", dut.phase_acc_q, 144);
    check("trk_w3_int", dut.int_acc_q, 48);

    // Integral saturation
    pd_in = 8'sd127;
    tick(28);
    check("sat_int", dut.int_acc_q, 2047);

    // Override to 0xFF then bumpless release and wrap
    rst = 1'b1; tick(1); rst = 1'b0;
    ext_ovrd = 1'b1; ext_code = 8'hFF;
    tick(3);
    check("ovrd_code", code_out, 8'hFF);
    ext_code = 8'h3C; tick(1);
    ext_code = 8'hFF; tick(2);
    ext_ovrd = 1'b0; pd_in = 8'sd4;
    tick(5);
    check("wrap_first_phase", dut.phase_acc_q, 32'hFF20);
    tick(16);
    check("wrap_code", code_out, 0);

    // Lock acquisition then loss
    lock_thr = 8'd2; pd_in = 8'sd0;
    tick(16);
    check("lock_set", lock, 1);
    pd_in = 8'sd2;
    tick(4);
    check("lock_lost", lock, 0);

    // Enable dropped mid-window, then a fresh window
    pd_in = 8'sd1;
    tick(2);
    en = 1'b0; tick(3);
    en = 1'b1; tick(4);
    check("abort_novld", code_vld, 0);
    tick(1);
    check("abort_vld", code_vld, 1);

    // Randomized operation
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom_range(0, 199));
      rst = (r == 0);
      if ($urandom_range(0, 99) < 3) ext_ovrd = ~ext_ovrd;
      if (ext_ovrd && $urandom_range(0, 1) == 1) ext_code = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 1) == 1) tmp = int'($urandom_range(0, 6)) - 3;
      else tmp = int'($urandom_range(0, 255)) - 128;
      pd_in = 8'(tmp);
      if ($urandom_range(0, 15) == 0) begin
        kp = 4'($urandom_range(0, 15));
        ki = 4'($urandom_range(0, 15));
        lock_thr = 8'($urandom_range(0, 20));
      end
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
